voice_alloc_n: RTL and testbench
================================

Name: voice_alloc_n

Overview:
Parametrised polyphonic voice allocator between the MIDI/synth controller and the synth engine. It turns serial note-on/note-off events into per-voice key state: keys_on, a note_on strobe, key address, key value and velocities. Voice choice uses voice_free from the envelope generator and a selectable allocation mode: first-free, steal-oldest or mono. It generalises fixed 8-voice allocation to any VOICES count and adds voice stealing, retrigger and an all-notes-off function.

Parameters:
VOICES, 8, number of voices
V_WIDTH, 3, voice index width; VOICES <= 2**V_WIDTH
AGE_WIDTH, 4, per-voice age counter width (saturating)

Ports:
OSC_CLK  in  1  single clock; all logic rising-edge
reset_reg  in  1  synchronous reset, active-high
evt_valid  in  1  note event present
evt_ready  out  1  allocator can accept an event
evt_is_on  in  1  1 = note-on, 0 = note-off
evt_key  in  8  MIDI key number
evt_vel  in  8  velocity (on or off)
mode  in  2  0 first-free/drop, 1 steal-oldest, 2 mono, 3 same as 0
all_off  in  1  pulse: release all voices
voice_free  in  VOICES  per-voice envelope idle flag from env gen
keys_on  out  VOICES  per-voice gate
note_on  out  1  one-cycle strobe on a new allocation
cur_key_adr  out  V_WIDTH  voice index of the last issued event
cur_key_val  out  8  key of the last issued event
cur_vel_on  out  8  velocity of the last issued note-on
cur_vel_off  out  8  velocity of the last issued note-off
drop_cnt  out  8  saturating count of dropped note-ons

Behaviour:
- Reset: keys_on=0, note_on=0, cur_* = 0, drop_cnt=0, all ages=0, evt_ready=0, FSM=IDLE. evt_ready goes 1 on the first cycle after reset_reg falls.
- FSM states: IDLE -> SCAN -> ISSUE -> IDLE.
- IDLE: evt_ready=1. evt_valid&evt_ready is the accept; event fields and mode are latched and evt_ready drops next cycle.
- SCAN: examines one voice per cycle, index 0..VOICES-1, exactly VOICES cycles. Per voice it records:
  - first key match: keys_on=1 and key equal;
  - first free voice: voice_free=1 and keys_on=0;
  - oldest active voice: greatest age; ties go to the lowest index.
- ISSUE, one cycle; outputs update on this edge.
- Note-on, modes 0/1/3, resolved in this priority:
  - key match: retrigger that voice;
  - else first free voice;
  - else mode 1: steal the oldest voice;
  - else modes 0/3: drop.
- Note-on, mode 2: always voice 0, no scan decision.
- Allocation or retrigger: keys_on[v]=1, note_on=1 for this cycle only, cur_key_adr=v, cur_key_val=key, cur_vel_on=vel. Age[v] is cleared; every other active voice's age increments, saturating at 2**AGE_WIDTH-1.
- Drop: no output change; drop_cnt increments, saturating at 255.
- Note-off:
  - Clears keys_on for the first matching voice only; note_on stays 0; cur_key_adr=v, cur_key_val=key, cur_vel_off=vel.
  - No match: ignored, no output change.
  - Mode 2: clears voice 0 only if its key equals evt_key.
- Latency: accept at cycle N -> ISSUE edge at N+VOICES+1 -> evt_ready=1 at N+VOICES+2.
- all_off: highest priority in any state. Next edge: keys_on=0, ages=0, FSM=IDLE; an in-flight event is discarded and not counted. all_off together with a same-cycle accept: the event is discarded.
- voice_free is sampled during SCAN only; changes after a voice has been scanned are ignored until the next event.
- mode changes while busy take effect at the next accept.
- reset_reg mid-SCAN: full reset values on the next edge; the event is lost.
- ISSUE writes keys_on only after the scan completes; keys_on is otherwise stable during SCAN.

Test Plan:
- VOICES=8, mode 0, all voice_free=1: note-ons for keys 60, 64, 67 -> voices 0, 1, 2; keys_on=8'h07; note_on exactly 3 single-cycle strobes, each 9 cycles after its accept.
- Same key again: note-on 64 vel 100 while voice 1 holds 64 -> retrigger on voice 1, keys_on unchanged, cur_vel_on=100, age[1]=0.
- Full, mode 0: 8 voices held, 9th note-on -> no note_on, drop_cnt=1. Mode 1, same stimulus -> the oldest voice (voice 0) is reassigned, cur_key_adr=0.
- Note-off key 67 vel 40 -> keys_on bit 2 cleared, cur_vel_off=40, note_on=0. Note-off for unheld key 50 -> no output change.
- Mode 2: note-on 60 then 62 -> both on voice 0, cur_key_val=62. Note-off 60 -> keys_on[0] stays 1. Note-off 62 -> keys_on[0]=0.
- all_off asserted mid-SCAN, and reset_reg asserted mid-SCAN -> keys_on=0 next edge, event discarded, evt_ready=1 the following cycle. For reset_reg, the first cycle after it deasserts.
- VOICES=16, V_WIDTH=4 rerun of the first scenario: latency 17 cycles accept-to-strobe.

Source files
------------

// File: rtl/voice_alloc_n_if.sv
// voice_alloc_n_if
//   Note-event handshake between the MIDI/synth controller (master) and the
//   voice allocator (slave). An event transfers on a cycle where evt_valid
//   and evt_ready are both high.
//   evt_valid  master -> slave  note event present
//   evt_ready  slave  -> master allocator can accept an event
//   evt_is_on  master -> slave  1 = note-on, 0 = note-off
//   evt_key    master -> slave  MIDI key number
//   evt_vel    master -> slave  velocity (on or off)
interface voice_alloc_n_if;
   logic       evt_valid;
   logic       evt_ready;
   logic       evt_is_on;
   logic [7:0] evt_key;
   logic [7:0] evt_vel;

   modport master (output evt_valid, evt_is_on, evt_key, evt_vel, input evt_ready);
   modport slave  (input evt_valid, evt_is_on, evt_key, evt_vel, output evt_ready);
endinterface

// File: rtl/voice_alloc_n.sv
// voice_alloc_n
//   Polyphonic voice allocator. Serial note events are turned into per-voice
//   gates. Each accepted event scans every voice (one per cycle), then one
//   ISSUE cycle applies the decision: retrigger, first-free allocation,
//   steal-oldest, mono (voice 0) or drop.
//   OSC_CLK      single rising-edge clock
//   reset_reg    synchronous active-high reset
//   evt          note-event handshake (slave side)
//   mode         0/3 first-free or drop, 1 steal-oldest, 2 mono
//   all_off      pulse: release every voice and abandon any in-flight event
//   voice_free   per-voice envelope idle flags from the envelope generator
//   keys_on      per-voice gate
//   note_on      one-cycle strobe on an allocation or retrigger
//   cur_key_adr  voice index of the last issued event
//   cur_key_val  key of the last issued event
//   cur_vel_on   velocity of the last issued note-on
//   cur_vel_off  velocity of the last issued note-off
//   drop_cnt     saturating count of dropped note-ons
module voice_alloc_n #(
   parameter int VOICES    = 8,
   parameter int V_WIDTH   = 3,
   parameter int AGE_WIDTH = 4
) (
   input  logic                OSC_CLK,
   input  logic                reset_reg,
   voice_alloc_n_if.slave      evt,
   input  logic [1:0]          mode,
   input  logic                all_off,
   input  logic [VOICES-1:0]   voice_free,
   output logic [VOICES-1:0]   keys_on,
   output logic                note_on,
   output logic [V_WIDTH-1:0]  cur_key_adr,
   output logic [7:0]          cur_key_val,
   output logic [7:0]          cur_vel_on,
   output logic [7:0]          cur_vel_off,
   output logic [7:0]          drop_cnt
);

   typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

   localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;
   localparam logic [V_WIDTH-1:0]   LAST_IDX = V_WIDTH'(VOICES - 1);

   state_t               state, state_nxt;
   logic                 ready_en;
   logic                 accept;

   logic                 lat_is_on;
   logic [7:0]           lat_key;
   logic [7:0]           lat_vel;
   logic [1:0]           lat_mode;

   logic [V_WIDTH-1:0]   scan_idx;
   logic                 match_found, free_found, old_found;
   logic [V_WIDTH-1:0]   match_idx, free_idx, old_idx;
   logic [AGE_WIDTH-1:0] old_age;

   logic [AGE_WIDTH-1:0] age [VOICES];
   logic [7:0]           voice_key [VOICES];

   logic [V_WIDTH-1:0]   tgt_idx;
   logic                 do_alloc, do_release, do_drop;

   // ready_en holds evt_ready low for the first cycle out of reset.
   assign evt.evt_ready = (state == IDLE) & ready_en;
   assign accept        = evt.evt_valid & evt.evt_ready;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge OSC_CLK) begin
      if (reset_reg) state <= IDLE;
      else           state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SCAN;
         SCAN:    if (scan_idx == LAST_IDX) state_nxt = ISSUE;
         ISSUE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (all_off) state_nxt = IDLE;
   end

   // Decision from the completed scan records.
   always_comb begin
      tgt_idx    = '0;
      do_alloc   = 1'b0;
      do_release = 1'b0;
      do_drop    = 1'b0;
      if (lat_mode == 2'd2) begin
         // Mono: voice 0 only; a note-off must name the key it holds.
         if (lat_is_on)                                  do_alloc   = 1'b1;
         else if (keys_on[0] && voice_key[0] == lat_key) do_release = 1'b1;
      end else if (lat_is_on) begin
         if (match_found) begin
            tgt_idx  = match_idx;
            do_alloc = 1'b1;
         end else if (free_found) begin
            tgt_idx  = free_idx;
            do_alloc = 1'b1;
         end else if (lat_mode == 2'd1 && old_found) begin
            tgt_idx  = old_idx;
            do_alloc = 1'b1;
         end else begin
            do_drop  = 1'b1;
         end
      end else if (match_found) begin
         tgt_idx    = match_idx;
         do_release = 1'b1;
      end
   end

   always_ff @(posedge OSC_CLK) begin
      if (reset_reg) begin
         ready_en    <= 1'b0;
         keys_on     <= '0;
         note_on     <= 1'b0;
         cur_key_adr <= '0;
         cur_key_val <= '0;
         cur_vel_on  <= '0;
         cur_vel_off <= '0;
         drop_cnt    <= '0;
         lat_is_on   <= 1'b0;
         lat_key     <= '0;
         lat_vel     <= '0;
         lat_mode    <= '0;
         scan_idx    <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         old_idx     <= '0;
         old_age     <= '0;
         for (int v = 0; v < VOICES; v++) age[v] <= '0;
      end else begin
         ready_en <= 1'b1;
         note_on  <= 1'b0;
         if (all_off) begin
            keys_on <= '0;
            for (int v = 0; v < VOICES; v++) age[v] <= '0;
         end else begin
            case (state)
               IDLE: if (accept) begin
                  lat_is_on   <= evt.evt_is_on;
                  lat_key     <= evt.evt_key;
                  lat_vel     <= evt.evt_vel;
                  lat_mode    <= mode;
                  scan_idx    <= '0;
                  match_found <= 1'b0;
                  free_found  <= 1'b0;
                  old_found   <= 1'b0;
               end
               SCAN: begin
                  if (!match_found && keys_on[scan_idx] && voice_key[scan_idx] == lat_key) begin
                     match_found <= 1'b1;
                     match_idx   <= scan_idx;
                  end
                  if (!free_found && voice_free[scan_idx] && !keys_on[scan_idx]) begin
                     free_found <= 1'b1;
                     free_idx   <= scan_idx;
                  end
                  // Strictly greater keeps the lowest index on an age tie.
                  if (keys_on[scan_idx] && (!old_found || age[scan_idx] > old_age)) begin
                     old_found <= 1'b1;
                     old_idx   <= scan_idx;
                     old_age   <= age[scan_idx];
                  end
                  scan_idx <= scan_idx + 1'b1;
               end
               ISSUE: begin
                  if (do_alloc) begin
                     keys_on[tgt_idx] <= 1'b1;
                     note_on          <= 1'b1;
                     cur_key_adr      <= tgt_idx;
                     cur_key_val      <= lat_key;
                     cur_vel_on       <= lat_vel;
                     for (int v = 0; v < VOICES; v++) begin
                        if (V_WIDTH'(v) == tgt_idx)              age[v] <= '0;
                        else if (keys_on[v] && age[v] != AGE_MAX) age[v] <= age[v] + 1'b1;
                     end
                  end
                  if (do_release) begin
                     keys_on[tgt_idx] <= 1'b0;
                     cur_key_adr      <= tgt_idx;
                     cur_key_val      <= lat_key;
                     cur_vel_off      <= lat_vel;
                  end
                  if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the key store is not reset; keys_on qualifies every read, so stale keys are harmless.
   always_ff @(posedge OSC_CLK) begin
      if (!reset_reg && !all_off && state == ISSUE && do_alloc) voice_key[tgt_idx] <= lat_key;
   end

endmodule

// File: tb/tb_voice_alloc_n.sv
// tb_voice_alloc_n
//   Scoreboard bench for voice_alloc_n: each event pushes its expected
//   outcome, and the outcome is popped and compared once the allocator
//   returns to ready. A second 16-voice instance checks the longer latency.
module tb_voice_alloc_n;
   localparam int VOICES = 8;

   logic OSC_CLK = 1'b0;
   always #5 OSC_CLK = ~OSC_CLK;

   logic              reset_reg;
   logic [1:0]        mode;
   logic              all_off;
   logic [VOICES-1:0] voice_free;
   logic [VOICES-1:0] keys_on;
   logic              note_on;
   logic [2:0]        cur_key_adr;
   logic [7:0]        cur_key_val, cur_vel_on, cur_vel_off, drop_cnt;

   logic [1:0]        mode16;
   logic              all_off16;
   logic [15:0]       voice_free16, keys_on16;
   logic              note_on16;
   logic [3:0]        adr16;
   logic [7:0]        key16, von16, voff16, drop16;

   voice_alloc_n_if evt8();
   voice_alloc_n_if evt16();

   voice_alloc_n #(.VOICES(8), .V_WIDTH(3), .AGE_WIDTH(4)) dut (
      .OSC_CLK(OSC_CLK), .reset_reg(reset_reg), .evt(evt8), .mode(mode), .all_off(all_off),
      .voice_free(voice_free), .keys_on(keys_on), .note_on(note_on), .cur_key_adr(cur_key_adr),
      .cur_key_val(cur_key_val), .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off),
      .drop_cnt(drop_cnt)
   );

   voice_alloc_n #(.VOICES(16), .V_WIDTH(4), .AGE_WIDTH(4)) dut16 (
      .OSC_CLK(OSC_CLK), .reset_reg(reset_reg), .evt(evt16), .mode(mode16), .all_off(all_off16),
      .voice_free(voice_free16), .keys_on(keys_on16), .note_on(note_on16), .cur_key_adr(adr16),
      .cur_key_val(key16), .cur_vel_on(von16), .cur_vel_off(voff16), .drop_cnt(drop16)
   );

   typedef struct {
      int         strobes;
      logic [7:0] keys;
      logic [2:0] adr;
      logic [7:0] key;
      logic [7:0] von;
      logic [7:0] voff;
      logic [7:0] drop;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge OSC_CLK);
      #1;
   endtask

   function automatic exp_t mk(input int s, input logic [7:0] k, input logic [2:0] a,
                               input logic [7:0] kv, input logic [7:0] von,
                               input logic [7:0] voff, input logic [7:0] drop);
      exp_t e;
      e.strobes = s; e.keys = k; e.adr = a; e.key = kv; e.von = von; e.voff = voff; e.drop = drop;
      return e;
   endfunction

   task automatic wait_ready(input string tag);
      for (int c = 0; c < 50 && !evt8.evt_ready; c++) tick();
      check(tag, 32'(evt8.evt_ready), 32'd1);
   endtask

   task automatic drive_accept(input logic is_on, input logic [7:0] key, input logic [7:0] vel);
      evt8.evt_valid = 1'b1;
      evt8.evt_is_on = is_on;
      evt8.evt_key   = key;
      evt8.evt_vel   = vel;
      tick();
      evt8.evt_valid = 1'b0;
   endtask

   // Issue one event, then compare the popped expectation with what the DUT did.
   task automatic send(input string tag, input logic is_on, input logic [7:0] key,
                       input logic [7:0] vel, input exp_t e);
      int   strobes   = 0;
      int   strobe_at = -1;
      int   ready_at  = -1;
      exp_t x;
      sb.push_back(e);
      wait_ready({tag, "_ready_in"});
      drive_accept(is_on, key, vel);
      for (int c = 1; c <= 40 && ready_at < 0; c++) begin
         tick();
         if (note_on) begin strobes++; strobe_at = c; end
         if (evt8.evt_ready) ready_at = c;
      end
      tick();
      if (note_on) strobes++;
      x = sb.pop_front();
      check({tag, "_ready_lat"}, 32'(ready_at), 32'(VOICES + 1));
      check({tag, "_strobes"},   32'(strobes),  32'(x.strobes));
      if (x.strobes > 0) check({tag, "_strobe_lat"}, 32'(strobe_at), 32'(VOICES + 1));
      check({tag, "_keys_on"},  32'(keys_on),     32'(x.keys));
      check({tag, "_adr"},      32'(cur_key_adr), 32'(x.adr));
      check({tag, "_key"},      32'(cur_key_val), 32'(x.key));
      check({tag, "_vel_on"},   32'(cur_vel_on),  32'(x.von));
      check({tag, "_vel_off"},  32'(cur_vel_off), 32'(x.voff));
      check({tag, "_drop_cnt"}, 32'(drop_cnt),    32'(x.drop));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time budget exceeded");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int strobes;
      int lat;

      reset_reg      = 1'b1;
      mode           = 2'd0;
      all_off        = 1'b0;
      voice_free     = '1;
      evt8.evt_valid = 1'b0;
      evt8.evt_is_on = 1'b0;
      evt8.evt_key   = '0;
      evt8.evt_vel   = '0;
      mode16          = 2'd0;
      all_off16       = 1'b0;
      voice_free16    = '1;
      evt16.evt_valid = 1'b0;
      evt16.evt_is_on = 1'b0;
      evt16.evt_key   = '0;
      evt16.evt_vel   = '0;

      repeat (3) tick();
      check("rst_keys_on",  32'(keys_on),        32'd0);
      check("rst_note_on",  32'(note_on),        32'd0);
      check("rst_ready",    32'(evt8.evt_ready), 32'd0);
      check("rst_cur_key",  32'(cur_key_val),    32'd0);
      check("rst_drop_cnt", 32'(drop_cnt),       32'd0);
      reset_reg = 1'b0;
      tick();
      check("rst_ready_rise", 32'(evt8.evt_ready), 32'd1);

      // Mode 0, all voices idle: fill in order, then retrigger.
      send("on60",     1'b1, 8'd60, 8'd90,  mk(1, 8'h01, 3'd0, 8'd60, 8'd90,  8'd0, 8'd0));
      send("on64",     1'b1, 8'd64, 8'd80,  mk(1, 8'h03, 3'd1, 8'd64, 8'd80,  8'd0, 8'd0));
      send("on67",     1'b1, 8'd67, 8'd70,  mk(1, 8'h07, 3'd2, 8'd67, 8'd70,  8'd0, 8'd0));
      send("retrig64", 1'b1, 8'd64, 8'd100, mk(1, 8'h07, 3'd1, 8'd64, 8'd100, 8'd0, 8'd0));
      for (int i = 0; i < 5; i++)
         send("fill", 1'b1, 8'(70 + i), 8'd50,
              mk(1, 8'((1 << (4 + i)) - 1), 3'(3 + i), 8'(70 + i), 8'd50, 8'd0, 8'd0));

      // Full: drop in mode 0, steal oldest (voice 0) in mode 1.
      send("drop80", 1'b1, 8'd80, 8'd55, mk(0, 8'hFF, 3'd7, 8'd74, 8'd50, 8'd0, 8'd1));
      mode = 2'd1;
      send("steal81", 1'b1, 8'd81, 8'd66, mk(1, 8'hFF, 3'd0, 8'd81, 8'd66, 8'd0, 8'd1));
      mode = 2'd0;

      // Note-offs: held key releases its voice; unheld key changes nothing.
      send("off67", 1'b0, 8'd67, 8'd40, mk(0, 8'hFB, 3'd2, 8'd67, 8'd66, 8'd40, 8'd1));
      send("off50", 1'b0, 8'd50, 8'd33, mk(0, 8'hFB, 3'd2, 8'd67, 8'd66, 8'd40, 8'd1));

      // A gate-off voice whose envelope is still busy is not free.
      voice_free = 8'hFB;
      send("busy90", 1'b1, 8'd90, 8'd20, mk(0, 8'hFB, 3'd2, 8'd67, 8'd66, 8'd40, 8'd2));
      voice_free = '1;
      send("on90", 1'b1, 8'd90, 8'd21, mk(1, 8'hFF, 3'd2, 8'd90, 8'd21, 8'd40, 8'd2));

      // Ages now make voice 1 the oldest, not the lowest index.
      mode = 2'd1;
      send("steal95", 1'b1, 8'd95, 8'd30, mk(1, 8'hFF, 3'd1, 8'd95, 8'd30, 8'd40, 8'd2));
      mode = 2'd0;

      // all_off in the middle of a scan.
      wait_ready("aoff_ready_in");
      drive_accept(1'b1, 8'd91, 8'd60);
      repeat (3) tick();
      all_off = 1'b1;
      tick();
      all_off = 1'b0;
      check("aoff_keys_on", 32'(keys_on),        32'd0);
      check("aoff_ready",   32'(evt8.evt_ready), 32'd1);
      strobes = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (note_on) strobes++;
      end
      check("aoff_no_strobe", 32'(strobes),     32'd0);
      check("aoff_drop_cnt",  32'(drop_cnt),    32'd2);
      check("aoff_cur_key",   32'(cur_key_val), 32'd95);

      // Mono mode.
      mode = 2'd2;
      send("m2_on60",  1'b1, 8'd60, 8'd11, mk(1, 8'h01, 3'd0, 8'd60, 8'd11, 8'd40, 8'd2));
      send("m2_on62",  1'b1, 8'd62, 8'd12, mk(1, 8'h01, 3'd0, 8'd62, 8'd12, 8'd40, 8'd2));
      send("m2_off60", 1'b0, 8'd60, 8'd13, mk(0, 8'h01, 3'd0, 8'd62, 8'd12, 8'd40, 8'd2));
      send("m2_off62", 1'b0, 8'd62, 8'd14, mk(0, 8'h00, 3'd0, 8'd62, 8'd12, 8'd14, 8'd2));
      mode = 2'd0;

      // reset_reg in the middle of a scan.
      wait_ready("rst2_ready_in");
      drive_accept(1'b1, 8'd65, 8'd70);
      repeat (3) tick();
      reset_reg = 1'b1;
      tick();
      check("rst2_keys_on",  32'(keys_on),        32'd0);
      check("rst2_cur_key",  32'(cur_key_val),    32'd0);
      check("rst2_vel_off",  32'(cur_vel_off),    32'd0);
      check("rst2_drop_cnt", 32'(drop_cnt),       32'd0);
      check("rst2_ready",    32'(evt8.evt_ready), 32'd0);
      reset_reg = 1'b0;
      tick();
      check("rst2_ready_rise", 32'(evt8.evt_ready), 32'd1);
      send("post_rst", 1'b1, 8'd65, 8'd77, mk(1, 8'h01, 3'd0, 8'd65, 8'd77, 8'd0, 8'd0));

      // all_off on the same cycle as an accept: the event is discarded.
      wait_ready("aoff2_ready_in");
      all_off = 1'b1;
      drive_accept(1'b1, 8'd70, 8'd99);
      all_off = 1'b0;
      check("aoff2_keys_on", 32'(keys_on),        32'd0);
      check("aoff2_ready",   32'(evt8.evt_ready), 32'd1);
      strobes = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (note_on) strobes++;
      end
      check("aoff2_no_strobe", 32'(strobes),     32'd0);
      check("aoff2_cur_key",   32'(cur_key_val), 32'd65);

      // 16 voices: accept-to-strobe latency is 17 cycles.
      for (int n = 0; n < 2; n++) begin
         for (int c = 0; c < 50 && !evt16.evt_ready; c++) tick();
         check("v16_ready_in", 32'(evt16.evt_ready), 32'd1);
         evt16.evt_valid = 1'b1;
         evt16.evt_is_on = 1'b1;
         evt16.evt_key   = 8'(60 + 4 * n);
         evt16.evt_vel   = 8'd90;
         tick();
         evt16.evt_valid = 1'b0;
         lat = -1;
         for (int c = 1; c <= 40 && lat < 0; c++) begin
            tick();
            if (note_on16) lat = c;
         end
         check("v16_latency", 32'(lat),   32'd17);
         check("v16_adr",     32'(adr16), 32'(n));
         check("v16_key",     32'(key16), 32'(60 + 4 * n));
         tick();
      end
      check("v16_keys_on", 32'(keys_on16), 32'h0003);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
